nibble_serial_adder: RTL and testbench

- Multi-cycle 16-bit adder, the additive counterpart of the team's registered subtractor.
- Adds two operands plus carry-in one 4-bit digit per clock, LSB digit first, rippling the carry through a register.
- Reports sum, carry-out and signed overflow with a start/busy/done handshake.
- Sits beside the subtractor in the arithmetic datapath, where area matters more than latency.

---
 rtl/arith_pkg.sv | 35 +++
 rtl/digit_adder.sv | 34 +++
 rtl/nibble_serial_adder.sv | 169 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Purpose  : Shared types and constants for the digit-serial arithmetic blocks.
//            - state_t   : IDLE / RUN / DONE sequencer states
//            - NDIGITS   : digits per operand at the default geometry
//            - CNT_W     : digit counter width at the default geometry
//            - SAT_POS/SAT_NEG : signed saturation limits at the default width
//            - cnt_width(): counter width for an arbitrary digit count
// Revision : 1.0  initial release
// ============================================================================
package arith_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;
    localparam int NDIGITS   = DEF_WIDTH / DEF_DIGIT;

    // A single-digit configuration still needs a 1-bit counter to be legal.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    localparam int CNT_W = cnt_width(NDIGITS);

    localparam logic [DEF_WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DEF_WIDTH-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_adder
// Purpose  : Combinational DIGIT-bit adder with carry-in.
// Ports    : x, y      - DIGIT-bit addends
//            ci        - carry in
//            s         - DIGIT-bit sum
//            co        - carry out of the top bit
//            c_msb_in  - carry into the top bit (for signed overflow)
// Revision : 1.0  initial release
// ============================================================================
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_full;

    assign w_full   = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    assign s        = w_full[DIGIT-1:0];
    assign co       = w_full[DIGIT];

    // The top sum bit is x^y^carry_in at that position, so the carry into
    // the top bit is recovered without a second adder chain.
    assign c_msb_in = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : Multi-cycle WIDTH-bit adder, DIGIT bits per clock, LSB first,
//            with the carry rippled through a register.
// Ports    : clk   - rising-edge clock
//            rst   - asynchronous active-low reset
//            start - request, sampled only while idle
//            a, b  - operands, captured on the accept edge
//            cin   - carry in, captured on the accept edge
//            busy  - high while digits are being added
//            done  - one-cycle pulse when sum/cout/ovf are valid
//            sum   - registered result, held until the next completion
//            cout  - unsigned carry out of the MSB
//            ovf   - signed two's-complement overflow
// Config   : NIBBLE_SERIAL_ADDER_SAT_EN - clamp sum to signed limits on
//            overflow (cout/ovf still report the raw condition).
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,   // must be a multiple of DIGIT
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_ndigits = WIDTH / DIGIT;
    localparam int c_cnt_w   = cnt_width(c_ndigits);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_ndigits - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_psum;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT-1:0]   w_s;
    logic               w_co;
    logic               w_c_msb_in;
    logic               w_last;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_psum_next;
    logic [WIDTH-1:0]   w_result;

    digit_adder #(
        .DIGIT    (DIGIT)
    ) u_digit_adder (
        .x        (r_a[DIGIT-1:0]),
        .y        (r_b[DIGIT-1:0]),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_c_msb_in)
    );

    assign w_last = (r_cnt == c_last);
    // Only meaningful on the last digit, which holds the operand MSBs.
    assign w_ovf  = w_c_msb_in ^ w_co;

    // Each new digit enters the partial sum from the top, so after the last
    // digit the word is already in its final bit order.
    generate
        if (WIDTH == DIGIT) begin : g_one_digit
            assign w_psum_next = w_s;
        end else begin : g_multi_digit
            assign w_psum_next = {w_s, r_psum[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow both operands share a sign and the raw MSB is its inverse:
    // a negative-looking raw result means two non-negative operands.
    always_comb begin
        w_result = w_psum_next;
        if (w_ovf) begin
            w_result = w_psum_next[WIDTH-1] ? c_sat_pos : c_sat_neg;
        end
    end
`else
    assign w_result = w_psum_next;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_psum  <= w_psum_next;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        r_sum  <= w_result;
                        r_cout <= w_co;
                        r_ovf  <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Self-checking bench for nibble_serial_adder: directed and random
//            additions compared with a signed/unsigned integer reference,
//            back-to-back handshake with start held high, and reset abort.
// Config   : NIBBLE_SERIAL_ADDER_SAT_EN - reference model clamps as well.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         cout;
    logic         ovf;
    logic [W-1:0] sum;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(
        .WIDTH (W),
        .DIGIT (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Reference: returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         ci);
        int unsigned u;
        int          sv;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        u  = int'(x) + int'(y) + int'(ci);
        sv = int'($signed(x)) + int'($signed(y)) + int'(ci);
        s  = W'(u % 65536);
        co = (u >= 65536);
        ov = (sv > 32767) || (sv < -32768);
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
        if (sv > 32767)  s = 16'h7FFF;
        if (sv < -32768) s = 16'h8000;
`endif
        return {ov, co, s};
    endfunction

    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input string name);
        logic [W+1:0] exp;
        int lat;
        exp = model(x, y, ci);
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (busy && done) begin
                n_vec++; n_err++;
                $display("FAIL %s busy_and_done: both high at edge +%0d", name, k);
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_vec++;
        if (lat != 4) begin
            n_err++;
            $display("FAIL %s latency: done seen %0d edges after accept, want 4 (0=timeout)", name, lat);
        end
        n_vec++;
        if ({ovf, cout, sum} !== exp) begin
            n_err++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, exp[W-1:0], exp[W], exp[W+1]);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== exp[W-1:0]) begin
            n_err++;
            $display("FAIL %s after_done: got done=%b busy=%b sum=%h want 0 0 %h",
                     name, done, busy, sum, exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, cout, ovf, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_in: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({busy, done, cout, ovf, sum} !== '0) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got busy=%b done=%b sum=%h want 0", k, busy, done, sum);
            end
        end
    endtask

    task automatic test_directed();
        run_add(16'h000A, 16'h0005, 1'b0, "add_a_5");
        run_add(16'h0FFF, 16'h0000, 1'b1, "ripple_cin");
        run_add(16'hFFFF, 16'h0001, 1'b0, "wrap_cout");
        run_add(16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
        run_add(16'h8000, 16'h8000, 1'b0, "neg_ovf");
        run_add(16'h8000, 16'hFFFF, 1'b1, "neg_edge");
        run_add(16'h7FFF, 16'h7FFF, 1'b1, "pos_max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ha [0:63];
        logic [W-1:0] hb [0:63];
        logic         hc [0:63];
        logic [W+1:0] exp;
        int last_done;
        int nres;
        last_done = -1;
        nres = 0;
        @(negedge clk);
        start = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int e = 0; e < 40 && nres < 4; e++) begin
            ha[e] = a; hb[e] = b; hc[e] = cin;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_vec++;
                if (e < 4) begin
                    n_err++;
                    $display("FAIL b2b_early: done at edge %0d", e);
                end else begin
                    exp = model(ha[e-4], hb[e-4], hc[e-4]);
                    if ({ovf, cout, sum} !== exp) begin
                        n_err++;
                        $display("FAIL b2b_result %0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 nres, sum, cout, ovf, exp[W-1:0], exp[W], exp[W+1]);
                    end
                end
                if (last_done >= 0) begin
                    n_vec++;
                    if (e - last_done != 6) begin
                        n_err++;
                        $display("FAIL b2b_interval: got %0d cycles want 6", e - last_done);
                    end
                end
                last_done = e;
                nres++;
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        n_vec++;
        if (nres != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results want 4", nres);
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int seen_done;
        run_add(16'hFFFF, 16'hFFFF, 1'b1, "pre_abort");
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, cout, ovf, sum} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk); rst = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_vec++;
        if (seen_done != 0 || sum !== '0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d busy/done cycles sum=%h want 0 and 0000", seen_done, sum);
        end
        run_add(16'h1234, 16'h4321, 1'b0, "post_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
